fp16_add_sequencer: RTL and testbench

// Upstream issue/collect stage wrapped around the 4-stage fp16 adder pipeline.

---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_add_sequencer_if.sv | 31 +++
 rtl/fp16_sync_fifo.sv | 51 +++++
 rtl/fp16_add_sequencer.sv | 94 +++++++++
 tb/tb_fp16_add_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the adder pipeline and its issue/collect sequencer.
// Field widths, adder latency and a packed field view of an fp16 word.
package fp16_pkg;

    localparam int FP16_W       = 16;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP16_ADD_LAT = 4;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp16_add_sequencer_if.sv
// Operand, adder and result ports of the fp16 add sequencer.
// slave = sequencer side, master = upstream/adder/consumer side.
interface fp16_add_sequencer_if
    import fp16_pkg::*;
#(
    parameter int FP_W = FP16_W
);

    logic            in_valid73;
    logic            in_ready73;
    logic [FP_W-1:0] in_a73;
    logic [FP_W-1:0] in_b73;
    logic [FP_W-1:0] add_a73;
    logic [FP_W-1:0] add_b73;
    logic [FP_W-1:0] add_sum73;
    logic            out_valid73;
    logic            out_ready73;
    logic [FP_W-1:0] out_sum73;
    logic            busy73;

    modport slave (
        input  in_valid73, in_a73, in_b73, add_sum73, out_ready73,
        output in_ready73, add_a73, add_b73, out_valid73, out_sum73, busy73
    );

    modport master (
        output in_valid73, in_a73, in_b73, add_sum73, out_ready73,
        input  in_ready73, add_a73, add_b73, out_valid73, out_sum73, busy73
    );

endinterface

// File: rtl/fp16_sync_fifo.sv
// First-word fall-through result FIFO with async-reset pointers and a count output.
module fp16_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rd_fire;

    // A read on an empty FIFO is ignored.
    assign rd_fire   = rd_en_i & (cnt_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_en_i, rd_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Issues operand pairs to the fixed-latency fp16 adder and collects sums in order.
// Define FP_ADD_SEQ_STATS_EN to add saturating issue/stall counters.
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter int FP_W  = FP16_W,
    parameter int LAT   = FP16_ADD_LAT,
    parameter int DEPTH = 8
) (
    input  logic                clk73,
    input  logic                rst73,
    fp16_add_sequencer_if.slave io
`ifdef FP_ADD_SEQ_STATS_EN
    ,
    output logic [31:0]         issue_cnt73,
    output logic [31:0]         stall_cnt73
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            accept, pop;
    logic [FP_W-1:0] a_q, b_q;
    logic [LAT:0]    vp_q, vp_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   fifo_cnt;

    // occ counts every op from accept to pop, so a FIFO slot always exists.
    assign io.in_ready73  = occ_q < CW'(DEPTH);
    assign accept         = io.in_valid73 & io.in_ready73;
    assign io.out_valid73 = fifo_cnt != '0;
    assign pop            = io.out_valid73 & io.out_ready73;
    assign io.busy73      = occ_q != '0;
    assign io.add_a73     = a_q;
    assign io.add_b73     = b_q;
    assign vp_d           = {vp_q[LAT-1:0], accept};

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk73 or posedge rst73) begin
        if (rst73) begin
            a_q   <= '0;
            b_q   <= '0;
            vp_q  <= '0;
            occ_q <= '0;
        end else begin
            if (accept) begin
                a_q <= io.in_a73;
                b_q <= io.in_b73;
            end
            vp_q  <= vp_d;
            occ_q <= occ_d;
        end
    end

    fp16_sync_fifo #(
        .W     (FP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk73),
        .rst_i     (rst73),
        .wr_en_i   (vp_q[LAT]),
        .wr_data_i (io.add_sum73),
        .rd_en_i   (pop),
        .rd_data_o (io.out_sum73),
        .count_o   (fifo_cnt)
    );

`ifdef FP_ADD_SEQ_STATS_EN
    logic [31:0] issue_q, stall_q;
    logic        stall;

    assign stall       = io.in_valid73 & ~io.in_ready73;
    assign issue_cnt73 = issue_q;
    assign stall_cnt73 = stall_q;

    always_ff @(posedge clk73 or posedge rst73) begin
        if (rst73) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept && issue_q != '1) issue_q <= issue_q + 32'd1;
            if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Bench for fp16_add_sequencer with a behavioural 4-stage fp16 adder and queue model.
// Define FP_ADD_SEQ_STATS_EN to also check the issue/stall counters.
module tb_fp16_add_sequencer;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp16_add_sequencer_if #(.FP_W(FP16_W)) sif ();

`ifdef FP_ADD_SEQ_STATS_EN
    logic [31:0] issue_cnt, stall_cnt;
`endif

    fp16_add_sequencer #(
        .FP_W  (16),
        .LAT   (4),
        .DEPTH (8)
    ) dut (
        .clk73 (clk),
        .rst73 (rst),
        .io    (sif.slave)
`ifdef FP_ADD_SEQ_STATS_EN
        ,
        .issue_cnt73 (issue_cnt),
        .stall_cnt73 (stall_cnt)
`endif
    );

    // fp16 values are exact integer multiples of 2^-24.
    function automatic longint fp_dec(logic [15:0] x);
        longint mag;
        if (x[14:10] == 5'd0) mag = longint'(x[9:0]);
        else mag = longint'({1'b1, x[9:0]}) << (x[14:10] - 5'd1);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] fp_enc(longint v);
        logic   s;
        longint mag, keep, rem, half;
        int     p, e, sh;
        s   = v < 0;
        mag = s ? -v : v;
        if (mag == 0) return 16'h0000;
        if (mag < 1024) return {s, 5'd0, mag[9:0]};
        p = 0;
        for (int i = 0; i < 48; i++) if (mag[i]) p = i;
        e    = p - 9;
        sh   = p - 10;
        keep = mag;
        if (sh > 0) begin
            keep = mag >> sh;
            rem  = mag & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == 2048) begin
                keep = 1024;
                e    = e + 1;
            end
        end
        return {s, e[4:0], keep[9:0]};
    endfunction

    function automatic logic [15:0] fp_add(logic [15:0] a, logic [15:0] b);
        return fp_enc(fp_dec(a) + fp_dec(b));
    endfunction

    function automatic logic [15:0] rnd_fp();
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        s = 1'($urandom);
        e = 5'($urandom_range(0, 29));
        m = 10'($urandom);
        return {s, e, m};
    endfunction

    // Unreset adder pipeline, latency 4 from add_a/add_b.
    logic [15:0] st [4];
    always_ff @(posedge clk) begin
        st[0] <= fp_add(sif.add_a73, sif.add_b73);
        st[1] <= st[0];
        st[2] <= st[1];
        st[3] <= st[2];
    end
    assign sif.add_sum73 = st[3];

    typedef struct {
        logic [15:0] sum;
        int          rdy;
    } ent_t;

    ent_t pend[$];
    int   edge_n   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   m_issue  = 0;
    int   m_stall  = 0;

    function automatic bit m_valid();
        return pend.size() != 0 && pend[0].rdy <= edge_n;
    endfunction

    function automatic bit m_ready();
        return pend.size() < 8;
    endfunction

    function automatic logic [15:0] m_sum();
        return pend.size() != 0 ? pend[0].sum : 16'h0000;
    endfunction

    // One clock: model decides handshakes from its own state, then returns at negedge.
    task automatic tick();
        bit          acc, pp, stl;
        logic [15:0] s;
        acc = !rst && sif.in_valid73 && m_ready();
        pp  = !rst && sif.out_ready73 && m_valid();
        stl = !rst && sif.in_valid73 && !m_ready();
        s   = fp_add(sif.in_a73, sif.in_b73);
        @(posedge clk);
        edge_n++;
        if (rst) begin
            pend.delete();
            m_issue = 0;
            m_stall = 0;
        end else begin
            if (pp) void'(pend.pop_front());
            if (acc) begin
                pend.push_back('{s, edge_n + 5});
                m_issue++;
            end
            if (stl) m_stall++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (sif.in_ready73 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", sif.in_ready73);
        end
        checks++;
        if (sif.out_valid73 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", sif.out_valid73);
        end
        checks++;
        if (sif.busy73 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", sif.busy73);
        end
        checks++;
        if (sif.add_a73 !== 16'h0000 || sif.add_b73 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_add_ab got=%h/%h exp=0000/0000",
                     sif.add_a73, sif.add_b73);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        sif.in_valid73 = 1'b1;
        sif.in_a73     = 16'h3C00;
        sif.in_b73     = 16'h4000;
        tick();
        sif.in_valid73 = 1'b0;
        checks++;
        if (sif.add_a73 !== 16'h3C00 || sif.add_b73 !== 16'h4000) begin
            failures++;
            $display("FAIL single_add_ab got=%h/%h exp=3c00/4000",
                     sif.add_a73, sif.add_b73);
        end
        lat = 0;
        while (!sif.out_valid73 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=5", lat);
        end
        checks++;
        if (sif.out_sum73 !== 16'h4200) begin
            failures++;
            $display("FAIL single_sum got=%h exp=4200", sif.out_sum73);
        end
        sif.out_ready73 = 1'b1;
        tick();
        sif.out_ready73 = 1'b0;
        checks++;
        if (sif.busy73 !== 1'b0 || sif.out_valid73 !== 1'b0) begin
            failures++;
            $display("FAIL single_pop busy=%b valid=%b exp=0/0",
                     sif.busy73, sif.out_valid73);
        end
    endtask

    task automatic test_backpressure();
        bit will_acc;
        int pops, guard;
        do_reset();
        sif.out_ready73 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.in_valid73 = 1'b1;
            sif.in_a73     = rnd_fp();
            sif.in_b73     = rnd_fp();
            tick();
            checks++;
            if (sif.in_ready73 !== (i < 7)) begin
                failures++;
                $display("FAIL bp_fill_ready i=%0d got=%b exp=%b",
                         i, sif.in_ready73, (i < 7));
            end
        end
        sif.in_a73 = rnd_fp();
        sif.in_b73 = rnd_fp();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sif.in_ready73 !== 1'b0 || sif.busy73 !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold ready=%b busy=%b exp=0/1",
                         sif.in_ready73, sif.busy73);
            end
        end
        sif.out_ready73 = 1'b1;
        pops  = 0;
        guard = 0;
        while ((pend.size() != 0 || sif.in_valid73) && guard < 100) begin
            will_acc = sif.in_valid73 && m_ready();
            if (sif.out_valid73) pops++;
            tick();
            guard++;
            if (will_acc) sif.in_valid73 = 1'b0;
            checks++;
            if (sif.out_valid73 !== m_valid() || sif.in_ready73 !== m_ready()) begin
                failures++;
                $display("FAIL bp_drain_flags valid=%b/%b ready=%b/%b",
                         sif.out_valid73, m_valid(), sif.in_ready73, m_ready());
            end
            if (m_valid()) begin
                checks++;
                if (sif.out_sum73 !== m_sum()) begin
                    failures++;
                    $display("FAIL bp_drain_sum got=%h exp=%h",
                             sif.out_sum73, m_sum());
                end
            end
        end
        sif.in_valid73  = 1'b0;
        sif.out_ready73 = 1'b0;
        checks++;
        if (guard >= 100 || pops !== 9) begin
            failures++;
            $display("FAIL bp_pops got=%0d exp=9 guard=%0d", pops, guard);
        end
`ifdef FP_ADD_SEQ_STATS_EN
        checks++;
        if (issue_cnt !== 32'd9) begin
            failures++;
            $display("FAIL stats_issue got=%0d exp=9", issue_cnt);
        end
        checks++;
        if (stall_cnt !== 32'(m_stall)) begin
            failures++;
            $display("FAIL stats_stall got=%0d exp=%0d", stall_cnt, m_stall);
        end
`endif
    endtask

    task automatic test_accept_pop_same();
        int pops, guard;
        do_reset();
        sif.out_ready73 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sif.in_valid73 = 1'b1;
            sif.in_a73     = rnd_fp();
            sif.in_b73     = rnd_fp();
            tick();
        end
        sif.in_valid73 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (sif.in_ready73 !== 1'b1 || sif.out_valid73 !== 1'b1) begin
            failures++;
            $display("FAIL ap_occ7 ready=%b valid=%b exp=1/1",
                     sif.in_ready73, sif.out_valid73);
        end
        sif.in_valid73  = 1'b1;
        sif.in_a73      = rnd_fp();
        sif.in_b73      = rnd_fp();
        sif.out_ready73 = 1'b1;
        tick();
        sif.in_valid73  = 1'b0;
        sif.out_ready73 = 1'b0;
        checks++;
        if (sif.in_ready73 !== 1'b1 || sif.busy73 !== 1'b1) begin
            failures++;
            $display("FAIL ap_same_edge ready=%b busy=%b exp=1/1",
                     sif.in_ready73, sif.busy73);
        end
        checks++;
        if (sif.out_sum73 !== m_sum()) begin
            failures++;
            $display("FAIL ap_next_head got=%h exp=%h", sif.out_sum73, m_sum());
        end
        sif.out_ready73 = 1'b1;
        pops  = 0;
        guard = 0;
        while (pend.size() != 0 && guard < 60) begin
            if (sif.out_valid73) pops++;
            if (m_valid()) begin
                checks++;
                if (sif.out_sum73 !== m_sum()) begin
                    failures++;
                    $display("FAIL ap_drain_sum got=%h exp=%h",
                             sif.out_sum73, m_sum());
                end
            end
            tick();
            guard++;
        end
        sif.out_ready73 = 1'b0;
        checks++;
        if (pops !== 7 || sif.busy73 !== 1'b0) begin
            failures++;
            $display("FAIL ap_no_loss pops=%0d exp=7 busy=%b", pops, sif.busy73);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        sif.out_ready73 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sif.in_valid73 = 1'b1;
            sif.in_a73     = rnd_fp();
            sif.in_b73     = rnd_fp();
            tick();
        end
        sif.in_valid73 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sif.out_valid73 !== 1'b0 || sif.busy73 !== 1'b0) begin
                failures++;
                $display("FAIL mid_rst_quiet cyc=%0d valid=%b busy=%b exp=0/0",
                         i, sif.out_valid73, sif.busy73);
            end
        end
        sif.in_valid73 = 1'b1;
        sif.in_a73     = 16'hC000;
        sif.in_b73     = 16'h3C00;
        tick();
        sif.in_valid73 = 1'b0;
        lat = 0;
        while (!sif.out_valid73 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 5 || sif.out_sum73 !== 16'hBC00) begin
            failures++;
            $display("FAIL mid_rst_next lat=%0d sum=%h exp=5/bc00",
                     lat, sif.out_sum73);
        end
        sif.out_ready73 = 1'b1;
        tick();
        sif.out_ready73 = 1'b0;
    endtask

    task automatic test_random();
        int guard;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sif.in_valid73  = ($urandom_range(0, 3) != 0);
            sif.in_a73      = rnd_fp();
            sif.in_b73      = rnd_fp();
            sif.out_ready73 = ($urandom_range(0, 99) < ((c % 100) < 50 ? 20 : 85));
            tick();
            checks++;
            if (sif.out_valid73 !== m_valid() || sif.in_ready73 !== m_ready() ||
                sif.busy73 !== (pend.size() != 0)) begin
                failures++;
                $display("FAIL rand_flags c=%0d valid=%b/%b ready=%b/%b busy=%b",
                         c, sif.out_valid73, m_valid(), sif.in_ready73,
                         m_ready(), sif.busy73);
            end
            if (m_valid()) begin
                checks++;
                if (sif.out_sum73 !== m_sum()) begin
                    failures++;
                    $display("FAIL rand_sum c=%0d got=%h exp=%h",
                             c, sif.out_sum73, m_sum());
                end
            end
        end
        sif.in_valid73  = 1'b0;
        sif.out_ready73 = 1'b1;
`ifdef FP_ADD_SEQ_STATS_EN
        checks++;
        if (issue_cnt !== 32'(m_issue) || stall_cnt !== 32'(m_stall)) begin
            failures++;
            $display("FAIL rand_stats issue=%0d/%0d stall=%0d/%0d",
                     issue_cnt, m_issue, stall_cnt, m_stall);
        end
`endif
        guard = 0;
        while (pend.size() != 0 && guard < 60) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 60 || sif.busy73 !== 1'b0) begin
            failures++;
            $display("FAIL rand_drain guard=%0d busy=%b exp=0", guard, sif.busy73);
        end
        sif.out_ready73 = 1'b0;
    endtask

    initial begin
        sif.in_valid73  = 1'b0;
        sif.in_a73      = 16'h0000;
        sif.in_b73      = 16'h0000;
        sif.out_ready73 = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_accept_pop_same();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
